// File: rtl/lsu_sram_responder_pkg.sv
// Shared encodings and lane helpers for the LSU scratchpad responder.
// Latency: combinational helpers only, no state.
// Backpressure: not applicable; pure types/functions.
package lsu_sram_responder_pkg;

   // Access size encodings shared with the LSU initiators.
   localparam logic [1:0] DATA_BYTE = 2'b00;
   localparam logic [1:0] DATA_HALF = 2'b01;
   localparam logic [1:0] DATA_WORD = 2'b10;

   // Responder FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_e;

   // Fault classification of a request; anything but FLT_NONE raises lsu_err.
   typedef enum logic [1:0] {
      FLT_NONE     = 2'd0,
      FLT_MISALIGN = 2'd1,
      FLT_RANGE    = 2'd2,
      FLT_TYPE     = 2'd3
   } lsu_fault_e;

   // Size/alignment check; an unknown size code is its own fault class.
   function automatic lsu_fault_e align_fault(input logic [1:0] typ, input logic [1:0] lo);
      lsu_fault_e f;
      f = FLT_NONE;
      case (typ)
         DATA_BYTE: f = FLT_NONE;
         DATA_HALF: f = lo[0] ? FLT_MISALIGN : FLT_NONE;
         DATA_WORD: f = (lo != 2'b00) ? FLT_MISALIGN : FLT_NONE;
         default:   f = FLT_TYPE;
      endcase
      return f;
   endfunction

   // Byte-write enables for the addressed lane(s).
   function automatic logic [3:0] lane_be(input logic [1:0] typ, input logic [1:0] lo);
      logic [3:0] be;
      be = 4'b0000;
      case (typ)
         DATA_BYTE: be = 4'b0001 << lo;
         DATA_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
         DATA_WORD: be = 4'b1111;
         default:   be = 4'b0000;
      endcase
      return be;
   endfunction

   // Replicate right-justified write data across lanes; the enables pick the target.
   function automatic logic [31:0] lane_wdata(input logic [1:0] typ, input logic [31:0] wdata);
      logic [31:0] w;
      w = wdata;
      case (typ)
         DATA_BYTE: w = {4{wdata[7:0]}};
         DATA_HALF: w = {2{wdata[15:0]}};
         default:   w = wdata;
      endcase
      return w;
   endfunction

   // Pull the addressed lane out of a word, right-justified and zero-extended.
   function automatic logic [31:0] lane_extract(input logic [1:0] typ, input logic [1:0] lo,
                                                input logic [31:0] word);
      logic [31:0] r;
      r = 32'h0;
      case (typ)
         DATA_BYTE: begin
            case (lo)
               2'd0:    r = {24'h0, word[7:0]};
               2'd1:    r = {24'h0, word[15:8]};
               2'd2:    r = {24'h0, word[23:16]};
               default: r = {24'h0, word[31:24]};
            endcase
         end
         DATA_HALF: r = lo[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
         DATA_WORD: r = word;
         default:   r = 32'h0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_sram_array.sv
// Single-port word SRAM with byte-write enables and a registered read port.
// Latency: read data appears one clock after an enabled read; writes commit at the edge.
// Backpressure: none; one access per enabled cycle, read data holds until the next read.
module lsu_sram_array #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Storage and read register: not reset, contents survive rst_n.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/lsu_sram_responder.sv
// LSU-side scratchpad responder: decodes, fault-checks and lane-steers lsu requests.
// Latency: writes done same cycle; reads done 1+READ_WAIT cycles after the request is sampled.
// Backpressure: requests are only sampled in IDLE; reads are held by the initiator until done.
module lsu_sram_responder
   import lsu_sram_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int unsigned READ_WAIT   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lsu_ren,
   input  logic        lsu_wen,
   input  logic [1:0]  lsu_type,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   output logic        lsu_done,
   output logic [31:0] lsu_rdata,
   output logic        lsu_err
);

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  WAIT_INIT = 4'(READ_WAIT);

   lsu_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  lo_q, lo_d;
   logic [1:0]  type_q, type_d;
   logic        fault_q, fault_d;

   logic [31:0] offset;
   lsu_fault_e  req_fault;
   logic        req_bad;

   logic          arr_en;
   logic          arr_we;
   logic [3:0]    arr_be;
   logic [AW-1:0] arr_addr;
   logic [31:0]   arr_wdata;
   logic [31:0]   arr_rdata;

   // Address decode and fault classification of the request currently on the bus.
   // BASE_ADDR is aligned to the window size, so the offset's low bits equal the address's.
   always_comb begin
      offset    = lsu_addr - BASE_ADDR;
      req_fault = (offset >= SPAN) ? FLT_RANGE : align_fault(lsu_type, offset[1:0]);
      req_bad   = (req_fault != FLT_NONE);
      arr_addr  = offset[AW+1:2];
      arr_be    = lane_be(lsu_type, offset[1:0]);
      arr_wdata = lane_wdata(lsu_type, lsu_wdata);
   end

   // FSM next state, array control and response outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lo_d      = lo_q;
      type_d    = type_q;
      fault_d   = fault_q;
      arr_en    = 1'b0;
      arr_we    = 1'b0;
      lsu_done  = 1'b0;
      lsu_err   = 1'b0;
      lsu_rdata = 32'h0;
      case (state_q)
         ST_IDLE: begin
            if (lsu_wen) begin
               // Write wins over a simultaneous read; FSM stays put for 1/cycle writes.
               lsu_done = 1'b1;
               lsu_err  = req_bad;
               arr_en   = ~req_bad;
               arr_we   = 1'b1;
            end else if (lsu_ren) begin
               // Array read issued now; its output register holds until RESP since
               // no other access can reach the array in WAIT/RESP.
               lo_d    = offset[1:0];
               type_d  = lsu_type;
               fault_d = req_bad;
               arr_en  = ~req_bad;
               if (READ_WAIT == 0) begin
                  state_d = ST_RESP;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            lsu_done  = 1'b1;
            lsu_err   = fault_q;
            lsu_rdata = fault_q ? 32'h0 : lane_extract(type_q, lo_q, arr_rdata);
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // State and latched read context; reset aborts any read in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         lo_q    <= 2'b00;
         type_q  <= DATA_WORD;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lo_q    <= lo_d;
         type_q  <= type_d;
         fault_q <= fault_d;
      end
   end

   lsu_sram_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk   (clk),
      .en    (arr_en),
      .we    (arr_we),
      .be    (arr_be),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

endmodule

// File: tb/tb_lsu_sram_responder.sv
// Directed bench for lsu_sram_responder: table of single accesses plus multi-cycle sequences.
// Two instances: READ_WAIT=1 for the main tests, READ_WAIT=3 for reset-abort tests.
// Inputs driven and outputs sampled around the falling clock edge.
module tb_lsu_sram_responder;
   import lsu_sram_responder_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, lsu_ren, lsu_wen, lsu_done, lsu_err;
   logic [1:0]  lsu_type;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;

   logic        r3_rst_n, r3_ren, r3_wen, r3_done, r3_err;
   logic [1:0]  r3_type;
   logic [31:0] r3_addr, r3_wdata, r3_rdata;

   int total = 0;
   int bad   = 0;

   lsu_sram_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0001_0000), .READ_WAIT(1)) dut (
      .clk(clk), .rst_n(rst_n), .lsu_ren(lsu_ren), .lsu_wen(lsu_wen), .lsu_type(lsu_type),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_done(lsu_done),
      .lsu_rdata(lsu_rdata), .lsu_err(lsu_err));

   lsu_sram_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0001_0000), .READ_WAIT(3)) dut3 (
      .clk(clk), .rst_n(r3_rst_n), .lsu_ren(r3_ren), .lsu_wen(r3_wen), .lsu_type(r3_type),
      .lsu_addr(r3_addr), .lsu_wdata(r3_wdata), .lsu_done(r3_done),
      .lsu_rdata(r3_rdata), .lsu_err(r3_err));

   typedef struct {
      logic        wr;
      logic [1:0]  typ;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vt [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Entered just after a falling edge; returns just after the next falling edge.
   task automatic do_write(input string name, input logic [1:0] typ, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_err);
      lsu_wen = 1'b1; lsu_type = typ; lsu_addr = addr; lsu_wdata = wdata;
      #1;
      chk({name, "_done"}, 32'(lsu_done), 32'd1);
      chk({name, "_err"}, 32'(lsu_err), 32'(exp_err));
      @(negedge clk);
      lsu_wen = 1'b0;
   endtask

   // Issue a held read, expect done exactly 2 cycles later, then one quiet IDLE cycle.
   task automatic do_read(input string name, input logic [1:0] typ, input logic [31:0] addr,
                          input logic [31:0] exp_rdata, input logic exp_err);
      int lat;
      lat = 0;
      lsu_ren = 1'b1; lsu_type = typ; lsu_addr = addr;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (lsu_done) begin
            lat = i;
            break;
         end
      end
      if (lat == 0) begin
         chk({name, "_timeout"}, 32'd0, 32'd1);
      end else begin
         chk({name, "_lat"}, 32'(lat), 32'd2);
         chk({name, "_rdata"}, lsu_rdata, exp_rdata);
         chk({name, "_err"}, 32'(lsu_err), 32'(exp_err));
      end
      lsu_ren = 1'b0;
      @(negedge clk);
      chk({name, "_quiet"}, 32'(lsu_done), 32'd0);
   endtask

   // Read on the READ_WAIT=3 instance, expecting done 4 cycles after the request.
   task automatic r3_read(input string name, input logic [31:0] addr, input logic [31:0] exp_rdata);
      int lat;
      lat = 0;
      r3_ren = 1'b1; r3_type = DATA_WORD; r3_addr = addr;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (r3_done) begin
            lat = i;
            break;
         end
      end
      if (lat == 0) begin
         chk({name, "_timeout"}, 32'd0, 32'd1);
      end else begin
         chk({name, "_lat"}, 32'(lat), 32'd4);
         chk({name, "_rdata"}, r3_rdata, exp_rdata);
      end
      r3_ren = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, last, cyc, extra;

      // Single-access table: sub-word lanes and fault cases.
      vt[0]  = '{1'b1, DATA_WORD, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0,          1'b0};
      vt[1]  = '{1'b0, DATA_WORD, 32'h0001_0000, 32'h0,          32'hDEAD_BEEF, 1'b0};
      vt[2]  = '{1'b1, DATA_WORD, 32'h0001_0080, 32'h1122_3344, 32'h0,          1'b0};
      vt[3]  = '{1'b1, DATA_BYTE, 32'h0001_0081, 32'h0000_00EE, 32'h0,          1'b0};
      vt[4]  = '{1'b0, DATA_WORD, 32'h0001_0080, 32'h0,          32'h1122_EE44, 1'b0};
      vt[5]  = '{1'b0, DATA_HALF, 32'h0001_0082, 32'h0,          32'h0000_1122, 1'b0};
      vt[6]  = '{1'b0, DATA_BYTE, 32'h0001_0083, 32'h0,          32'h0000_0011, 1'b0};
      vt[7]  = '{1'b1, DATA_WORD, 32'h0001_0084, 32'h5566_7788, 32'h0,          1'b0};
      vt[8]  = '{1'b1, DATA_HALF, 32'h0001_0086, 32'h1234_ABCD, 32'h0,          1'b0};
      vt[9]  = '{1'b0, DATA_WORD, 32'h0001_0084, 32'h0,          32'hABCD_7788, 1'b0};
      vt[10] = '{1'b0, DATA_BYTE, 32'h0001_0084, 32'h0,          32'h0000_0088, 1'b0};
      vt[11] = '{1'b0, DATA_WORD, 32'h0001_0002, 32'h0,          32'h0,          1'b1};
      vt[12] = '{1'b0, DATA_HALF, 32'h0001_0081, 32'h0,          32'h0,          1'b1};
      vt[13] = '{1'b0, 2'b11,     32'h0001_0080, 32'h0,          32'h0,          1'b1};
      vt[14] = '{1'b0, DATA_WORD, 32'h0000_FFFC, 32'h0,          32'h0,          1'b1};

      rst_n = 1'b0; lsu_ren = 1'b0; lsu_wen = 1'b0; lsu_type = DATA_WORD;
      lsu_addr = 32'h0; lsu_wdata = 32'h0;
      r3_rst_n = 1'b0; r3_ren = 1'b0; r3_wen = 1'b0; r3_type = DATA_WORD;
      r3_addr = 32'h0; r3_wdata = 32'h0;

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      chk("rst_done", 32'(lsu_done), 32'd0);
      chk("rst_rdata", lsu_rdata, 32'h0);
      chk("rst_err", 32'(lsu_err), 32'd0);
      rst_n = 1'b1; r3_rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 15; i++) begin
         if (vt[i].wr)
            do_write($sformatf("vec%0d", i), vt[i].typ, vt[i].addr, vt[i].wdata, vt[i].exp_err);
         else
            do_read($sformatf("vec%0d", i), vt[i].typ, vt[i].addr, vt[i].exp_rdata, vt[i].exp_err);
      end

      // Preload words 0..11, then an out-of-window write that must not alias onto word 0.
      for (int i = 0; i < 12; i++)
         do_write($sformatf("pre%0d", i), DATA_WORD, 32'h0001_0000 + 32'(4 * i), 32'h100 + 32'(i), 1'b0);
      do_write("oob_wr", DATA_WORD, 32'h0001_1000, 32'hBAD0_BAD0, 1'b1);
      do_read("oob_check", DATA_WORD, 32'h0001_0000, 32'h0000_0100, 1'b0);

      // Multiplier-style fetch: ren held, address advanced in each done cycle.
      k = 0; last = 0; cyc = 0;
      lsu_ren = 1'b1; lsu_type = DATA_WORD; lsu_addr = 32'h0001_0000;
      while (k < 12 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (lsu_done) begin
            chk($sformatf("fetch%0d_rdata", k), lsu_rdata, 32'h100 + 32'(k));
            if (k > 0) chk($sformatf("fetch%0d_gap", k), 32'(cyc - last), 32'd3);
            last = cyc;
            k++;
            lsu_addr = 32'h0001_0000 + 32'(4 * k);
            if (k == 12) lsu_ren = 1'b0;
         end
      end
      lsu_ren = 1'b0;
      chk("fetch_count", 32'(k), 32'd12);
      chk("fetch_span", 32'(last), 32'd35);
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (lsu_done) extra++;
      end
      chk("fetch_extra_done", 32'(extra), 32'd0);

      // Four back-to-back writes, one per cycle, each done in its own cycle.
      for (int i = 0; i < 4; i++) begin
         lsu_wen = 1'b1; lsu_type = DATA_WORD;
         lsu_addr = 32'h0001_0040 + 32'(4 * i); lsu_wdata = 32'hA0 + 32'(i);
         #1;
         chk($sformatf("b2b%0d_done", i), 32'(lsu_done), 32'd1);
         chk($sformatf("b2b%0d_err", i), 32'(lsu_err), 32'd0);
         @(negedge clk);
      end
      lsu_wen = 1'b0;
      for (int i = 0; i < 4; i++)
         do_read($sformatf("b2b_rd%0d", i), DATA_WORD, 32'h0001_0040 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);

      // Illegal write while a read is in WAIT: no done, no memory update.
      lsu_ren = 1'b1; lsu_type = DATA_WORD; lsu_addr = 32'h0001_0040;
      @(negedge clk);
      lsu_wen = 1'b1; lsu_wdata = 32'h9999_9999;
      #1;
      chk("wait_wr_done", 32'(lsu_done), 32'd0);
      @(negedge clk);
      lsu_wen = 1'b0;
      chk("wait_wr_resp_done", 32'(lsu_done), 32'd1);
      chk("wait_wr_resp_rdata", lsu_rdata, 32'h0000_00A0);
      lsu_ren = 1'b0;
      @(negedge clk);
      do_read("wait_wr_mem", DATA_WORD, 32'h0001_0040, 32'h0000_00A0, 1'b0);

      // READ_WAIT=3 instance: baseline write and read.
      r3_wen = 1'b1; r3_type = DATA_WORD; r3_addr = 32'h0001_0010; r3_wdata = 32'h3333_0001;
      #1;
      chk("r3_wr_done", 32'(r3_done), 32'd1);
      @(negedge clk);
      r3_wen = 1'b0;
      r3_read("r3_base", 32'h0001_0010, 32'h3333_0001);

      // Reset in the second WAIT cycle aborts the read.
      r3_ren = 1'b1; r3_addr = 32'h0001_0010;
      @(negedge clk);
      @(negedge clk);
      r3_rst_n = 1'b0;
      r3_ren = 1'b0;
      #1;
      chk("r3_wait_rst_done", 32'(r3_done), 32'd0);
      chk("r3_wait_rst_rdata", r3_rdata, 32'h0);
      @(negedge clk);
      r3_rst_n = 1'b1;
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (r3_done) extra++;
      end
      chk("r3_wait_rst_no_done", 32'(extra), 32'd0);
      r3_read("r3_after_wait_rst", 32'h0001_0010, 32'h3333_0001);

      // Reset in the RESP cycle drops done asynchronously.
      r3_ren = 1'b1; r3_addr = 32'h0001_0010;
      cyc = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (r3_done) begin
            cyc = i;
            break;
         end
      end
      chk("r3_resp_reached", 32'(cyc), 32'd4);
      r3_rst_n = 1'b0;
      r3_ren = 1'b0;
      #1;
      chk("r3_resp_rst_done", 32'(r3_done), 32'd0);
      chk("r3_resp_rst_rdata", r3_rdata, 32'h0);
      chk("r3_resp_rst_err", 32'(r3_err), 32'd0);
      @(negedge clk);
      r3_rst_n = 1'b1;
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (r3_done) extra++;
      end
      chk("r3_resp_rst_no_done", 32'(extra), 32'd0);
      r3_read("r3_after_resp_rst", 32'h0001_0010, 32'h3333_0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_sram_responder.md
# lsu_sram_responder

Memory-side responder for the core/accelerator LSU request interface: a word-organised scratchpad SRAM with configurable read wait states that services `lsu_ren`/`lsu_wen` requests and returns `lsu_done`/`lsu_rdata`. It sits on the data bus behind initiators such as the Montgomery multiplier and the core LSU. It supports their protocol exactly: reads with a held request, and writes issued back-to-back one per cycle.

## Interface
- `DEPTH_WORDS`, 1024 — number of 32-bit words; power of two.
- `BASE_ADDR`, 32'h0001_0000 — byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `READ_WAIT`, 1 — extra cycles between read acceptance and `lsu_done`; range 0..15.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `lsu_ren`  in  1  read request; held high by the initiator until `lsu_done`.
- `lsu_wen`  in  1  write request; one write per cycle while high.
- `lsu_type`  in  2  access size: `DATA_BYTE`, `DATA_HALF`, `DATA_WORD` (shared defines).
- `lsu_addr`  in  32  byte address.
- `lsu_wdata`  in  32  write data, right-justified for byte/half.
- `lsu_done`  out  1  completion pulse.
- `lsu_rdata`  out  32  read data, right-justified and zero-extended; valid only while `lsu_done` is high for a read.
- `lsu_err`  out  1  asserted together with `lsu_done` for a faulted access.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE + `lsu_wen`**
  - The write commits at the next clock edge.
  - `lsu_done` is driven combinationally high in the same cycle.
  - FSM stays in IDLE, so back-to-back writes run at 1/cycle.
  - `lsu_wen` takes priority over `lsu_ren` when both are high; the read is dropped.
- **IDLE + `lsu_ren` (and not `lsu_wen`)**
  - Latch the address and type.
  - Go to WAIT with the wait counter = `READ_WAIT`, or go directly to RESP if `READ_WAIT`==0.
  - The array read is issued so data is registered on entry to RESP.
- **WAIT:** decrement the counter; at 0 go to RESP. Request inputs are ignored.
- **RESP:** `lsu_done`=1 and `lsu_rdata`/`lsu_err` valid for exactly one cycle. Return to IDLE. Inputs are ignored during RESP.
  - The initiator may already present its next address in the RESP cycle. That request is sampled in the following IDLE cycle.
- **Lane rules:** the word index is `(addr-BASE_ADDR)>>2`.
  - BYTE writes lane `addr[1:0]` from `wdata[7:0]`.
  - HALF writes lane `addr[1]` from `wdata[15:0]`.
  - WORD writes all 4 lanes.
  - Reads extract the same lane, right-justified and zero-extended.
- **Faults:** the access is not performed, `lsu_rdata`=0, and `lsu_err`=1 with `lsu_done`. A fault is any of:
  - misalignment: HALF with `addr[0]`=1, or WORD with `addr[1:0]`≠0;
  - address outside `[BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4)`;
  - illegal `lsu_type` (2'b11).
- Faulted reads still follow the IDLE→WAIT→RESP timing.

## Timing
- **Reset values:** `lsu_done`=0, `lsu_rdata`=0, `lsu_err`=0, state IDLE, wait counter 0. Memory contents are not cleared.
- **Read latency:** `lsu_ren` sampled in cycle T produces `lsu_done` in cycle T+1+`READ_WAIT`. The next read can be sampled at T+2+`READ_WAIT` at the earliest.
  - A 12-word sequential fetch with `READ_WAIT`=1 therefore takes 36 cycles.
- **Write latency:** `lsu_done` is in the same cycle as `lsu_wen`; data is readable by any read sampled in a later cycle.
- **Reset mid-operation:** asserting `rst_n`=0 in WAIT or RESP aborts immediately. No `lsu_done` is produced, and the outputs return to their reset values asynchronously.
- A write presented during WAIT/RESP is not accepted and gets no `lsu_done`. Initiators must not issue one; the bench flags it.
- `lsu_done` never asserts for two consecutive read responses without an intervening IDLE cycle.

## Structure
- `lsu_type` encodings (`DATA_BYTE`=2'b00, `DATA_HALF`=2'b01, `DATA_WORD`=2'b10) stay in the shared `riscv_defines.v`.
- FSM state encodings and the fault code go in a new shared header, `lsu_sram_defines.v`.
- Sub-module `lsu_sram_array`:
  - single-port, synchronous-read `DEPTH_WORDS`×32 array;
  - 4-bit byte-write enable;
  - no reset on the storage.
- The top level holds the FSM, address decode, fault checks and lane steering. Target size is about 200 lines.

## Test plan
1. `READ_WAIT`=1. Write WORD 0xDEADBEEF @0x10000, then read WORD @0x10000. Expect:
   - write `lsu_done` in the same cycle;
   - read `lsu_done` 2 cycles after `ren` sampled, with `rdata`=0xDEADBEEF and `err`=0.
2. Preload words 0..11 = 0x100+i. Run a multiplier-style fetch with 12 reads, advancing the address in the `done` cycle. Expect:
   - 12 `done` pulses, 3 cycles apart;
   - `rdata` sequence 0x100..0x10B;
   - no double acceptance.
3. Hold `wen` for 4 consecutive cycles: WORD writes 0xA0..0xA3 @0x10040..0x1004C. Then read back. Expect:
   - 4 same-cycle `done` pulses;
   - read values 0xA0..0xA3.
4. Sub-word access. Word = 0x11223344:
   - BYTE write 0xEE @+1 → word reads 0x1122EE44;
   - HALF read @+2 → `rdata`=0x00001122;
   - BYTE read @+3 → 0x00000011.
5. Faults:
   - WORD read @0x10002 → `done`+`err`, `rdata`=0;
   - WORD write @`BASE_ADDR`+`DEPTH_WORDS`*4 → `done`+`err`, and memory is unchanged.
6. `READ_WAIT`=3. Start a read, assert `rst_n` low in the 2nd WAIT cycle. Expect:
   - outputs 0 immediately;
   - no `done` after release;
   - a new read completes normally.
